// File: rtl/regfile_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bist_pkg
// Purpose  : State encoding and test-pattern helpers for the register-file BIST
// Revision : 1.0
// ============================================================================
package regfile_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] PAT_BASE = 32'hA5A5_0000;

  // Phase 1 stores the complement so every cell is exercised at both polarities.
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic phase);
    logic [31:0] p0;
    p0 = PAT_BASE | addr;
    return phase ? ~p0 : p0;
  endfunction

  function automatic logic [31:0] expected(input logic [31:0] addr, input logic phase,
                                           input logic skip_r0);
    if (skip_r0 && (addr == 32'd0)) return 32'd0;
    return pattern(addr, phase);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bist.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bist
// Purpose  : Write/read-back self-test initiator for a 2R1W register file
// Revision : 1.0
// ============================================================================
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter bit SKIP_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              fail_port,
  output logic              fail_phase,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic [ADDR_W-1:0] address_w,
  output logic [DATA_W-1:0] busW,
  output logic              RegWr,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB
);

  localparam logic [ADDR_W-1:0] K_LAST = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic                phase_q, phase_d;
  logic                pass_q, pass_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                fail_port_q, fail_port_d;
  logic                fail_phase_q, fail_phase_d;

  logic [ADDR_W-1:0]   k_mirror;
  logic [DATA_W-1:0]   pat_w, exp_a, exp_b;
  logic                mis_a, mis_b;
  logic                in_write, in_read;

  // Port B walks the array from the top so both ports cover every entry per pass.
  assign k_mirror = ~k_q;
  assign pat_w    = DATA_W'(pattern(32'(k_q), phase_q));
  assign exp_a    = DATA_W'(expected(32'(k_q), phase_q, SKIP_R0));
  assign exp_b    = DATA_W'(expected(32'(k_mirror), phase_q, SKIP_R0));
  assign mis_a    = (busA != exp_a);
  assign mis_b    = (busB != exp_b);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    phase_d      = phase_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_port_d  = fail_port_q;
    fail_phase_d = fail_phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_WRITE;
          k_d          = '0;
          phase_d      = 1'b0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          fail_port_d  = 1'b0;
          fail_phase_d = 1'b0;
        end
      end
      ST_WRITE: begin
        k_d = k_q + ADDR_W'(1);
        if (k_q == K_LAST) state_d = ST_READ;
      end
      ST_READ: begin
        k_d = k_q + ADDR_W'(1);
        if (mis_a || mis_b) begin
          // Port A wins a same-cycle double mismatch.
          state_d      = ST_DONE;
          k_d          = '0;
          pass_d       = 1'b0;
          fail_phase_d = phase_q;
          fail_port_d  = ~mis_a;
          fail_addr_d  = mis_a ? k_q  : k_mirror;
          fail_data_d  = mis_a ? busA : busB;
        end else if (k_q == K_LAST) begin
          if (!phase_q) begin
            state_d = ST_WRITE;
            phase_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      phase_q      <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_port_q  <= 1'b0;
      fail_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      phase_q      <= phase_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_port_q  <= fail_port_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  // Register-file side is decoded from state only, so reset silences it at once.
  assign in_write   = (state_q == ST_WRITE);
  assign in_read    = (state_q == ST_READ);
  assign busy       = in_write || in_read;
  assign done       = (state_q == ST_DONE);
  assign RegWr      = in_write;
  assign address_w  = in_write ? k_q      : '0;
  assign busW       = in_write ? pat_w    : '0;
  assign address_a  = in_read  ? k_q      : '0;
  assign address_b  = in_read  ? k_mirror : '0;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_port  = fail_port_q;
  assign fail_phase = fail_phase_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_bist
// Purpose  : Scoreboard bench: register-file model with injectable faults
// Revision : 1.0
// ============================================================================
module tb_regfile_bist;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  typedef struct {
    logic          pass;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          port;
    logic          phase;
    int            lat;
    int            writes;
    int            e0;
    int            wb;
    int            eb;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start0, start1;

  logic          busy0, done0, pass0, fp0, fph0, wr0;
  logic [AW-1:0] fa0, aa0, ab0, aw0;
  logic [DW-1:0] fd0, bw0, busA0, busB0;
  logic          busy1, done1, pass1, fp1, fph1, wr1;
  logic [AW-1:0] fa1, aa1, ab1, aw1;
  logic [DW-1:0] fd1, bw1, busA1, busB1;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  int   fault = 0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   wcnt0 = 0;
  int   werr0 = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  regfile_bist #(.ADDR_W(AW), .DATA_W(DW), .SKIP_R0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_addr(fa0), .fail_data(fd0), .fail_port(fp0), .fail_phase(fph0),
    .address_a(aa0), .address_b(ab0), .address_w(aw0), .busW(bw0), .RegWr(wr0),
    .busA(busA0), .busB(busB0)
  );

  regfile_bist #(.ADDR_W(AW), .DATA_W(DW), .SKIP_R0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fa1), .fail_data(fd1), .fail_port(fp1), .fail_phase(fph1),
    .address_a(aa1), .address_b(ab1), .address_w(aw1), .busW(bw1), .RegWr(wr1),
    .busA(busA1), .busB(busB1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr0) mem0[aw0] <= bw0;
    if (wr1) mem1[aw1] <= bw1;
  end

  // Fault modes: 1 entry5 bit0 SA0, 2 entry10 bit31 SA1, 3 busB@63 bit4 flip, 4 entry0 tied 0.
  function automatic logic [DW-1:0] rd(input logic [DW-1:0] v, input logic [AW-1:0] a,
                                       input logic portb, input int f);
    logic [DW-1:0] r;
    r = v;
    if (f == 1 && a == 6'd5)  r[0]  = 1'b0;
    if (f == 2 && a == 6'd10) r[31] = 1'b1;
    if (f == 3 && portb && a == 6'd63) r[4] = ~r[4];
    if (f == 4 && a == 6'd0)  r = '0;
    return r;
  endfunction

  assign busA0 = rd(mem0[aa0], aa0, 1'b0, fault);
  assign busB0 = rd(mem0[ab0], ab0, 1'b1, fault);
  assign busA1 = (aa1 == 6'd0) ? '0 : mem1[aa1];
  assign busB1 = (ab1 == 6'd0) ? '0 : mem1[ab1];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Independent write-stream checker: nth write of a run goes to n%64 with phase by n/64.
  always @(negedge clk) begin
    if (wr0) begin
      logic [31:0] p;
      int n;
      n = wcnt0 - sb_wbase();
      p = 32'hA5A5_0000 | 32'(n % DEPTH);
      if (n >= DEPTH) p = ~p;
      if (aw0 != AW'(n % DEPTH) || bw0 != p) werr0++;
      wcnt0++;
    end
  end

  function automatic int sb_wbase();
    return (sb0.size() != 0) ? sb0[0].wb : wcnt0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (sb0.size() == 0) cmp("dut0_spurious_done", {31'b0, done0}, 32'd0);
      else begin
        e = sb0.pop_front();
        cmp("dut0_pass",       {31'b0, pass0}, {31'b0, e.pass});
        cmp("dut0_fail_addr",  32'(fa0), 32'(e.addr));
        cmp("dut0_fail_data",  fd0, e.data);
        cmp("dut0_fail_port",  {31'b0, fp0}, {31'b0, e.port});
        cmp("dut0_fail_phase", {31'b0, fph0}, {31'b0, e.phase});
        cmp("dut0_done_lat",   32'(cyc - e.e0), 32'(e.lat));
        cmp("dut0_busy_in_done", {31'b0, busy0}, 32'd0);
        cmp("dut0_writes",     32'(wcnt0 - e.wb), 32'(e.writes));
        cmp("dut0_write_errs", 32'(werr0 - e.eb), 32'd0);
      end
    end
    if (done1) begin
      if (sb1.size() == 0) cmp("dut1_spurious_done", {31'b0, done1}, 32'd0);
      else begin
        e = sb1.pop_front();
        cmp("dut1_pass",      {31'b0, pass1}, {31'b0, e.pass});
        cmp("dut1_fail_addr", 32'(fa1), 32'(e.addr));
        cmp("dut1_fail_data", fd1, e.data);
        cmp("dut1_fail_port", {31'b0, fp1}, {31'b0, e.port});
        cmp("dut1_done_lat",  32'(cyc - e.e0), 32'(e.lat));
      end
    end
  end

  function automatic exp_t mk(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic port, input logic ph, input int lat, input int wr);
    exp_t e;
    e.pass = p; e.addr = a; e.data = d; e.port = port; e.phase = ph;
    e.lat = lat; e.writes = wr; e.e0 = 0; e.wb = 0; e.eb = 0;
    return e;
  endfunction

  task automatic wait_empty();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (sb0.size() == 0 && sb1.size() == 0) return;
    end
    cmp("run_timeout", 32'(sb0.size() + sb1.size()), 32'd0);
    sb0.delete();
    sb1.delete();
  endtask

  task automatic run(input int which, input int f, input exp_t e);
    fault = f;
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    e.e0 = cyc;
    e.wb = wcnt0;
    e.eb = werr0;
    if (which == 0) sb0.push_back(e); else sb1.push_back(e);
    wait_empty();
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_ctl"},  {26'b0, busy0, done0, pass0, fp0, fph0, wr0}, 32'd0);
    cmp({tag, "_addr"}, {8'b0, fa0, aa0, ab0, aw0}, 32'd0);
    cmp({tag, "_data"}, fd0 | bw0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    run(0, 0, mk(1'b1, 6'd0,  32'h0000_0000, 1'b0, 1'b0, 256, 128));
    repeat (3) @(negedge clk);
    cmp("pass_held", {31'b0, pass0}, 32'd1);
    run(0, 1, mk(1'b0, 6'd5,  32'hA5A5_0004, 1'b0, 1'b0, 70,  64));
    run(0, 2, mk(1'b0, 6'd10, 32'hDA5A_FFF5, 1'b0, 1'b1, 203, 128));
    run(0, 3, mk(1'b0, 6'd63, 32'hA5A5_002F, 1'b1, 1'b0, 65,  64));
    run(0, 4, mk(1'b0, 6'd0,  32'h0000_0000, 1'b0, 1'b0, 65,  64));
    run(1, 0, mk(1'b1, 6'd0,  32'h0000_0000, 1'b0, 1'b0, 256, 0));

    // Mid-run reset at WRITE k=20, with a stray start during the run.
    fault = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (10) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    cmp("stray_start_ignored_k20", 32'(aw0), 32'd20);
    cmp("regwr_before_rst", {31'b0, wr0}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_zero("midrun_reset");
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    cmp("idle_after_reset", {31'b0, busy0}, 32'd0);
    run(0, 0, mk(1'b1, 6'd0, 32'h0000_0000, 1'b0, 1'b0, 256, 128));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
